// File: rtl/reset_sequencer.sv
// Ordered PLL/reset bring-up for a chain of clock domains, with lock-loss recovery.
// Optional lock-loss event counter: define RESET_SEQUENCER_LOCK_LOSS_COUNTER_EN.
module reset_sequencer #(
  parameter int NUMBER_OF_STAGES = 3,
  parameter int PLL_RESET_CYCLES = 4,
  parameter int TIMEOUT_CYCLES   = 1024,
  parameter int HOLDOFF_CYCLES   = 16,
  parameter int MAX_RETRIES      = 3,
  localparam int KW = ($clog2(NUMBER_OF_STAGES) > 1) ? $clog2(NUMBER_OF_STAGES) : 1,
  localparam int RW = $clog2(MAX_RETRIES + 1)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUMBER_OF_STAGES-1:0] stage_locked,
  input  logic                        restart,
  output logic [NUMBER_OF_STAGES-1:0] stage_pll_reset,
  output logic [NUMBER_OF_STAGES-1:0] stage_reset,
  output logic                        all_released,
  output logic                        error,
  output logic [KW-1:0]               current_stage,
  output logic [RW-1:0]               retry_count,
  output logic [7:0]                  lock_loss_count
);
  localparam int N    = NUMBER_OF_STAGES;
  localparam int MAX1 = (TIMEOUT_CYCLES > HOLDOFF_CYCLES) ? TIMEOUT_CYCLES : HOLDOFF_CYCLES;
  localparam int MAXC = (MAX1 > PLL_RESET_CYCLES) ? MAX1 : PLL_RESET_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  typedef enum logic [2:0] {S_PLL_RESET, S_WAIT_LOCK, S_SETTLE, S_RUNNING, S_FAULT} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d, retry_inc;
  logic          recover_q, recover_d;
  logic [N-1:0]  sreset_q, sreset_d, pll_q, pll_d;
  logic [N-1:0]  sync1, lock_s, loss;
  logic [KW-1:0] loss_idx;
  logic          loss_any, restart_acc, release_k;

  // A stage is released exactly when its downstream reset is low.
  assign loss        = ~sreset_q & ~lock_s;
  assign loss_any    = |loss;
  assign restart_acc = restart && (state_q == S_RUNNING || state_q == S_FAULT);
  assign retry_inc   = retry_q + RW'(1);

  always_comb begin
    loss_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (loss[i]) loss_idx = KW'(i);
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_PLL_RESET;
      k_q       <= '0;
      cnt_q     <= '0;
      retry_q   <= '0;
      recover_q <= 1'b0;
      sreset_q  <= '1;
      pll_q     <= '0;
      sync1     <= '0;
      lock_s    <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      recover_q <= recover_d;
      sreset_q  <= sreset_d;
      pll_q     <= pll_d;
      sync1     <= stage_locked;
      lock_s    <= sync1;
    end
  end

  // Next-state
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    cnt_d     = '0;
    retry_d   = retry_q;
    recover_d = recover_q;
    release_k = 1'b0;
    if (restart_acc) begin
      state_d   = S_PLL_RESET;
      k_d       = '0;
      retry_d   = '0;
      recover_d = 1'b0;
    end else if (loss_any) begin
      // Recovery re-waits for lock without pulsing the PLLs that were already up.
      state_d   = S_WAIT_LOCK;
      k_d       = loss_idx;
      retry_d   = '0;
      recover_d = 1'b1;
    end else begin
      case (state_q)
        S_PLL_RESET: begin
          if (cnt_q == CW'(PLL_RESET_CYCLES - 1)) state_d = S_WAIT_LOCK;
          else cnt_d = cnt_q + CW'(1);
        end
        S_WAIT_LOCK: begin
          if (lock_s[k_q]) state_d = S_SETTLE;
          else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RW'(MAX_RETRIES)) ? S_FAULT : S_PLL_RESET;
          end else cnt_d = cnt_q + CW'(1);
        end
        S_SETTLE: begin
          if (!lock_s[k_q]) state_d = S_WAIT_LOCK;
          else if (cnt_q == CW'(HOLDOFF_CYCLES - 1)) begin
            release_k = 1'b1;
            retry_d   = '0;
            if (k_q == KW'(N - 1)) begin
              state_d   = S_RUNNING;
              recover_d = 1'b0;
            end else begin
              k_d     = k_q + KW'(1);
              state_d = recover_q ? S_WAIT_LOCK : S_PLL_RESET;
            end
          end else cnt_d = cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered outputs; the PLL pulse tracks the state being entered.
  always_comb begin
    sreset_d = sreset_q;
    if (restart_acc || state_d == S_FAULT) sreset_d = '1;
    else if (loss_any) begin
      for (int i = 0; i < N; i++)
        if (KW'(i) >= loss_idx) sreset_d[i] = 1'b1;
    end else if (release_k) sreset_d = sreset_q & ~(N'(1) << k_q);
    pll_d = (state_d == S_PLL_RESET) ? (N'(1) << k_d) : '0;
  end

  assign stage_pll_reset = pll_q;
  assign stage_reset     = sreset_q;
  assign all_released    = (state_q == S_RUNNING);
  assign error           = (state_q == S_FAULT);
  assign current_stage   = k_q;
  assign retry_count     = retry_q;

`ifdef RESET_SEQUENCER_LOCK_LOSS_COUNTER_EN
  logic [7:0] llc_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) llc_q <= '0;
    else if (loss_any && !restart_acc && state_q == S_RUNNING && llc_q != 8'hFF)
      llc_q <= llc_q + 8'd1;
  end
  assign lock_loss_count = llc_q;
`else
  assign lock_loss_count = 8'd0;
`endif
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed scenarios plus randomized lock/restart stimulus against a phase-level model.
module tb_reset_sequencer;
  localparam int N = 3, PRC = 4, TOC = 64, HOC = 8, MR = 2;
  localparam int P_PLL = 0, P_WAIT = 1, P_SET = 2, P_RUN = 3, P_FLT = 4;

  logic         clock = 1'b0;
  logic         reset, restart;
  logic [N-1:0] stage_locked;
  logic [N-1:0] stage_pll_reset, stage_reset;
  logic         all_released, error;
  logic [1:0]   current_stage, retry_count;
  logic [7:0]   lock_loss_count;

  reset_sequencer #(.NUMBER_OF_STAGES(N), .PLL_RESET_CYCLES(PRC), .TIMEOUT_CYCLES(TOC),
                    .HOLDOFF_CYCLES(HOC), .MAX_RETRIES(MR)) dut (
    .clock(clock), .reset(reset), .stage_locked(stage_locked), .restart(restart),
    .stage_pll_reset(stage_pll_reset), .stage_reset(stage_reset), .all_released(all_released),
    .error(error), .current_stage(current_stage), .retry_count(retry_count),
    .lock_loss_count(lock_loss_count));

  always #5 clock = ~clock;

  int checks = 0, errors = 0, edge_n = 0;

  // Model: phase, stage index, time spent in phase, count of released stages.
  int m_phase, m_k, m_t, m_retry, m_rel, m_llc;
  bit m_recover, m_fresh;
  logic [N-1:0] m_s1, m_s2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_PLL; m_k = 0; m_t = 0; m_retry = 0; m_rel = 0; m_llc = 0;
    m_recover = 0; m_fresh = 1; m_s1 = '0; m_s2 = '0;
  endtask

  task automatic model_tick();
    logic [N-1:0] ls;
    int j;
    bit racc;
    ls = m_s2; j = -1;
    m_s2 = m_s1; m_s1 = stage_locked; m_fresh = 0;
    racc = restart && (m_phase == P_RUN || m_phase == P_FLT);
    if (!racc)
      for (int i = m_rel - 1; i >= 0; i--) if (!ls[i]) j = i;
    if (racc) begin
      m_phase = P_PLL; m_k = 0; m_t = 0; m_retry = 0; m_rel = 0; m_recover = 0;
    end else if (j >= 0) begin
`ifdef RESET_SEQUENCER_LOCK_LOSS_COUNTER_EN
      if (m_phase == P_RUN && m_llc < 255) m_llc++;
`endif
      m_phase = P_WAIT; m_k = j; m_rel = j; m_t = 0; m_retry = 0; m_recover = 1;
    end else begin
      case (m_phase)
        P_PLL: begin
          m_t++;
          if (m_t == PRC) begin m_phase = P_WAIT; m_t = 0; end
        end
        P_WAIT: begin
          if (ls[m_k]) begin m_phase = P_SET; m_t = 0; end
          else begin
            m_t++;
            if (m_t == TOC) begin
              m_retry++; m_t = 0;
              if (m_retry == MR) begin m_phase = P_FLT; m_rel = 0; end
              else m_phase = P_PLL;
            end
          end
        end
        P_SET: begin
          if (!ls[m_k]) begin m_phase = P_WAIT; m_t = 0; end
          else begin
            m_t++;
            if (m_t == HOC) begin
              m_rel = m_k + 1; m_retry = 0; m_t = 0;
              if (m_k == N - 1) begin m_phase = P_RUN; m_recover = 0; end
              else begin m_k++; m_phase = m_recover ? P_WAIT : P_PLL; end
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare();
    logic [N-1:0] sr, pll;
    sr = '0;
    for (int i = 0; i < N; i++) sr[i] = (i >= m_rel);
    pll = (m_phase == P_PLL && !m_fresh) ? (N'(1) << m_k) : '0;
    chk("stage_reset", 32'(stage_reset), 32'(sr));
    chk("stage_pll_reset", 32'(stage_pll_reset), 32'(pll));
    chk("all_released", 32'(all_released), 32'(m_phase == P_RUN));
    chk("error", 32'(error), 32'(m_phase == P_FLT));
    chk("current_stage", 32'(current_stage), 32'(m_k));
    chk("retry_count", 32'(retry_count), 32'(m_retry));
    chk("lock_loss_count", 32'(lock_loss_count), 32'(m_llc));
  endtask

  task automatic step();
    @(posedge clock);
    edge_n++;
    model_tick();
    #1;
    compare();
  endtask

  // Reset takes effect without an edge; released at the next falling edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare();
    @(negedge clock);
    reset = 1'b0;
    edge_n = 0;
  endtask

  int f0, f1, f2, ar, w1, w2, pulses, n;
  logic prev;

  initial begin
    reset = 1'b1; restart = 1'b0; stage_locked = '0;
    #1;
    model_reset();
    compare();

    // 1: nominal power-up
    stage_locked = '1;
    @(negedge clock); reset = 1'b0; edge_n = 0;
    f0 = 0; f1 = 0; f2 = 0; ar = 0; w1 = 0; w2 = 0;
    for (int c = 0; c < 45; c++) begin
      step();
      if (stage_reset[0] === 1'b0 && f0 == 0) f0 = edge_n;
      if (stage_reset[1] === 1'b0 && f1 == 0) f1 = edge_n;
      if (stage_reset[2] === 1'b0 && f2 == 0) f2 = edge_n;
      if (all_released === 1'b1 && ar == 0) ar = edge_n;
      if (stage_pll_reset[1] === 1'b1) w1++;
      if (stage_pll_reset[2] === 1'b1) w2++;
    end
    chk("s1_release0_edge", f0, 13);
    chk("s1_release1_edge", f1, 26);
    chk("s1_release2_edge", f2, 39);
    chk("s1_all_released_edge", ar, 39);
    chk("s1_pll1_width", w1, PRC);
    chk("s1_pll2_width", w2, PRC);

    // 2: stage 1 never locks -> two attempts then FAULT
    stage_locked = 3'b101;
    do_reset();
    pulses = 0; prev = 1'b0; n = 0;
    while (error !== 1'b1 && n < 400) begin
      step(); n++;
      if (stage_pll_reset[1] === 1'b1 && prev === 1'b0) pulses++;
      prev = stage_pll_reset[1];
    end
    chk("s2_error", 32'(error), 1);
    chk("s2_retry", 32'(retry_count), MR);
    chk("s2_stage_reset", 32'(stage_reset), 32'h7);
    chk("s2_pll1_pulses", pulses, 2);
    stage_locked = '1;
    restart = 1'b1; step(); restart = 1'b0;
    n = 0;
    while (all_released !== 1'b1 && n < 80) begin step(); n++; end
    chk("s2_restart_released", 32'(all_released), 1);

    // 3: 3-cycle lock glitch on stage 0, five cycles into SETTLE
    stage_locked = '1;
    do_reset();
    repeat (10) step();
    stage_locked[0] = 1'b0;
    repeat (3) step();
    stage_locked[0] = 1'b1;
    chk("s3_retry", 32'(retry_count), 0);
    n = 0;
    while (stage_reset[0] !== 1'b0 && n < 60) begin step(); n++; end
    chk("s3_release0_edge", edge_n, 24);
    n = 0;
    while (all_released !== 1'b1 && n < 60) begin step(); n++; end

    // 4: stages 1 and 2 lose lock together while running
    stage_locked = 3'b001;
    n = 0;
    while (stage_reset !== 3'b110 && n < 3) begin step(); n++; end
    chk("s4_stage_reset", 32'(stage_reset), 32'h6);
    chk("s4_current_stage", 32'(current_stage), 1);
    chk("s4_all_released", 32'(all_released), 0);
    stage_locked = '1;
    pulses = 0; n = 0;
    while (all_released !== 1'b1 && n < 60) begin
      step(); n++;
      if (stage_pll_reset !== 3'b000) pulses++;
    end
    chk("s4_relock_released", 32'(all_released), 1);
    chk("s4_pll_pulses", pulses, 0);
`ifdef RESET_SEQUENCER_LOCK_LOSS_COUNTER_EN
    chk("s4_lock_loss_count", 32'(lock_loss_count), 1);
`else
    chk("s4_lock_loss_count", 32'(lock_loss_count), 0);
`endif

    // 5: reset during stage-1 SETTLE, then a clean restart
    repeat (2) step();
    do_reset();
    repeat (20) step();
    chk("s5_before_reset", 32'(stage_reset), 32'h6);
    do_reset();
    chk("s5_async_reset", 32'(stage_reset), 32'h7);
    f0 = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (stage_reset[0] === 1'b0 && f0 == 0) f0 = edge_n;
    end
    chk("s5_release0_edge", f0, 13);

    // Randomized lock drops, restarts and occasional resets
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      if ($urandom_range(0, 24) == 0) stage_locked = N'($urandom);
      else if ($urandom_range(0, 9) == 0) stage_locked = '1;
      restart = ($urandom_range(0, 59) == 0);
      step();
    end
    restart = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
